// File: rtl/count_seg_scan_if.sv
// count_seg_scan_if: counter value/direction in, multiplexed seven-segment drive out.
interface count_seg_scan_if;
  logic [3:0] cnt;
  logic       ud;
  logic [6:0] seg;
  logic [2:0] digit;
  logic       frame;
  modport master (output cnt, ud, input seg, digit, frame);
  modport slave (input cnt, ud, output seg, digit, frame);
endinterface

// File: rtl/count_seg_scan.sv
// count_seg_scan: 3-digit multiplexed seven-segment scanner for a 4-bit up/down counter.
module count_seg_scan #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC = 2
) (
  input logic clk,
  input logic rst,
  count_seg_scan_if.slave bus
);
  localparam int KW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(REFRESH_DIV - 1);
  localparam logic [KW-1:0] K_BLANK = KW'(BLANK_CYC);
  localparam logic [6:0] G_U = 7'b0111110;
  localparam logic [6:0] G_D = 7'b0111101;
  typedef enum logic [1:0] {S_ONES, S_TENS, S_DIR} state_t;
  state_t state, state_d;
  logic [KW-1:0] k, k_d;
  logic run, cap, tens;
  logic [3:0] cnt_q, cnt_d, ones;
  logic ud_q, ud_d;
  logic [6:0] seg_d;
  logic [2:0] digit_d;
  logic frame_d;
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: glyph = 7'b1111110;
      4'd1: glyph = 7'b0110000;
      4'd2: glyph = 7'b1101101;
      4'd3: glyph = 7'b1111001;
      4'd4: glyph = 7'b0110011;
      4'd5: glyph = 7'b1011011;
      4'd6: glyph = 7'b1011111;
      4'd7: glyph = 7'b1110000;
      4'd8: glyph = 7'b1111111;
      4'd9: glyph = 7'b1111011;
      default: glyph = 7'b0000000;
    endcase
  endfunction
  // Outputs are computed from next-state values so the registered drive lines up with the slot counter.
  always_comb begin
    state_d = state;
    k_d = (!run || k == K_LAST) ? '0 : k + KW'(1);
    if (run && k == K_LAST)
      state_d = state == S_ONES ? S_TENS : state == S_TENS ? S_DIR : S_ONES;
    cap = !run || (state == S_DIR && k == K_LAST);
    cnt_d = cap ? bus.cnt : cnt_q;
    ud_d = cap ? bus.ud : ud_q;
    tens = cnt_d >= 4'd10;
    ones = tens ? cnt_d - 4'd10 : cnt_d;
    seg_d = '0;
    digit_d = 3'b111;
    frame_d = state_d == S_DIR && k_d == K_LAST;
    if (k_d >= K_BLANK && !(state_d == S_TENS && !tens)) begin
      digit_d = state_d == S_ONES ? 3'b110 : state_d == S_TENS ? 3'b101 : 3'b011;
      seg_d = state_d == S_ONES ? glyph(ones) : state_d == S_TENS ? glyph(4'd1) : (ud_d ? G_U : G_D);
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_ONES;
      k <= '0;
      run <= 1'b0;
      cnt_q <= '0;
      ud_q <= 1'b1;
      bus.seg <= '0;
      bus.digit <= 3'b111;
      bus.frame <= 1'b0;
    end else begin
      state <= state_d;
      k <= k_d;
      run <= 1'b1;
      cnt_q <= cnt_d;
      ud_q <= ud_d;
      bus.seg <= seg_d;
      bus.digit <= digit_d;
      bus.frame <= frame_d;
    end
  end
endmodule

// File: doc/count_seg_scan.md
# count_seg_scan

Downstream display stage for the 4-bit up/down counter. It takes the counter value `out[3:0]` and direction `ud` and drives a 3-digit multiplexed seven-segment display:

- Digit 0: decimal ones of the count.
- Digit 1: decimal tens, blanked when zero.
- Digit 2: direction glyph, `U` or `d`.

A refresh divider time-slices the digits and inserts blanking gaps between slots. Inputs are snapshotted once per frame, so a frame never mixes two count values.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles per digit slot; must be > `BLANK_CYC`.
- `BLANK_CYC`, default 2: cycles at the start of each slot with all digits off (anti-ghosting).
- `clk`  input  1  system clock, rising edge.
- `rst`  input  1  reset; one clock, reset is asynchronous and active-low.
- `cnt`  input  4  counter value, 0–15, from the counter stage.
- `ud`  input  1  counter direction: 1 = up, 0 = down.
- `seg`  output  7  segment drive, active-high, `seg[6]`=a … `seg[0]`=g.
- `digit`  output  3  digit enables, active-low, one-hot-zero; `digit[0]`=ones, `digit[1]`=tens, `digit[2]`=direction.
- `frame`  output  1  one-cycle pulse marking the last cycle of each 3-slot frame.

## Operation
- Slot FSM states: `S_ONES` → `S_TENS` → `S_DIR` → `S_ONES`, each lasting exactly `REFRESH_DIV` cycles.
- A slot counter runs 0..`REFRESH_DIV`-1 and wraps to 0 on the state change.
- Snapshot registers `cnt_q` and `ud_q` capture `cnt` and `ud` only on the edge that begins `S_ONES`. Input changes at any other time have no effect until the next frame.
- BCD conversion of `cnt_q`:
  - tens = 1 if `cnt_q` ≥ 10, else 0.
  - ones = `cnt_q` − 10·tens, a 4-bit result in the range 0–9.
- Glyph encodings (abcdefg):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - `U`=0111110, `d`=0111101
- Slot cycles k < `BLANK_CYC`: `digit`=111, `seg`=0000000.
- Slot cycles k ≥ `BLANK_CYC`: the active digit's enable is 0, the others are 1, and `seg` carries that slot's glyph.
- Leading-zero blanking: in `S_TENS` with tens=0, `digit`=111 and `seg`=0 for the whole slot.
- Direction slot: `ud_q`=1 → `U`; `ud_q`=0 → `d`.
- `frame`=1 only during the last cycle (k=`REFRESH_DIV`-1) of `S_DIR`.
- All outputs are registered. No combinational path from `cnt` or `ud` to any output.

## Timing
- While `rst`=0 (asynchronous):
  - FSM = `S_ONES`, slot counter = 0.
  - `cnt_q`=0, `ud_q`=1.
  - `seg`=0000000, `digit`=111, `frame`=0.
- E0 is the first rising edge after `rst` deasserts. E0 begins `S_ONES` and captures the snapshot.
- Later captures occur at E0 + n·3·`REFRESH_DIV`.
- Output timeline after E0, one `REFRESH_DIV`-cycle slot at a time:
  - Cycles 0..`BLANK_CYC`-1: blank.
  - Cycles `BLANK_CYC`..`REFRESH_DIV`-1: ones digit.
  - Next slot: tens, same blank-then-glyph structure.
  - Next slot: direction, same structure.
  - Then repeat.
- Latency from a `cnt` change to the display is at most 3·`REFRESH_DIV` + `BLANK_CYC` cycles.
- Wrap-around values from the counter (15→0, 0→15) need no special handling; each frame shows whichever value was captured.
- An input change on the capture edge itself is taken if it met setup. There is no partial-frame update.
- Reset asserted mid-slot forces the reset values immediately, without waiting for a clock. The next deassertion restarts at E0 with a fresh capture.
- Exactly one `digit` bit is low at any time, or none. Two low bits simultaneously is an error.

## Test plan
Directed scenarios use `REFRESH_DIV`=8, `BLANK_CYC`=2.

- Reset hold, then release with `cnt`=7, `ud`=1:
  - While `rst`=0: `seg`=0, `digit`=111.
  - Slot 0: cycles 0–1 blank; cycles 2–7 `digit`=110, `seg`=1110000.
  - Slot 1 (tens=0): `digit`=111 for all 8 cycles.
  - Slot 2: cycles 2–7 `digit`=011, `seg`=0111110.
  - `frame`=1 at cycle 23 only.
- `cnt`=13, `ud`=0 held for a full frame:
  - Ones slot `seg`=1111001 (3).
  - Tens slot `digit`=101, `seg`=0110000 (1).
  - Direction slot `seg`=0111101 (`d`).
- Change `cnt` 13→14 at cycle 10 of a frame:
  - The remainder of that frame still shows 1 and 3.
  - The next frame's ones slot shows 4 (0110011).
- Sweep `cnt` through 0..15, one value per frame:
  - Every frame's ones/tens glyphs equal the decimal value.
  - Tens is blanked for values 0–9.
  - Checker asserts at most one `digit` bit low on every cycle.
- Assert `rst`=0 asynchronously mid-`S_TENS` (between clock edges):
  - `digit`=111, `seg`=0, `frame`=0 before the next edge.
  - After release, the ones slot restarts at E0 with the new capture.
- Counter wrap: `cnt` 15 then 0, `ud`=1, in consecutive frames:
  - First frame shows 1, 5, `U`.
  - Second frame shows 0 with tens blanked, then `U`.
